// File: rtl/telemetry_tx.sv
// Periodic telemetry framer: snapshots battery/current/torque and feeds a 9-byte
// frame (AA 55, six payload bytes, inverted checksum) to a byte-wide UART.
module telemetry_tx #(
  parameter int PERIOD_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] batt_v,
  input  logic [11:0] avg_curr,
  input  logic [11:0] avg_torque,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        busy
);

  localparam logic [23:0] RELOAD = 24'(PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t      state_q;
  logic [23:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [3:0]  idx_q;
  logic        guard_q;
  logic [7:0]  csum_q;
  logic [11:0] snap_v_q, snap_c_q, snap_t_q;
  logic        trmt_q, busy_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  cur_byte;
  logic        tick, start;

  assign tick  = (cnt_q == 24'd0);
  assign start = (state_q == IDLE) && pend_q && en;

  // A tick in the same cycle a frame starts re-arms pending for the next frame.
  always_comb begin
    cnt_d  = tick ? RELOAD : cnt_q - 24'd1;
    pend_d = pend_q;
    if (start)       pend_d = 1'b0;
    if (tick && en)  pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= RELOAD;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      4'd0: cur_byte = 8'hAA;
      4'd1: cur_byte = 8'h55;
      4'd2: cur_byte = {4'h0, snap_v_q[11:8]};
      4'd3: cur_byte = snap_v_q[7:0];
      4'd4: cur_byte = {4'h0, snap_c_q[11:8]};
      4'd5: cur_byte = snap_c_q[7:0];
      4'd6: cur_byte = {4'h0, snap_t_q[11:8]};
      4'd7: cur_byte = snap_t_q[7:0];
      4'd8: cur_byte = ~csum_q;
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      guard_q   <= 1'b0;
      csum_q    <= 8'h00;
      snap_v_q  <= 12'h000;
      snap_c_q  <= 12'h000;
      snap_t_q  <= 12'h000;
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      trmt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_q && en) begin
            snap_v_q <= batt_v;
            snap_c_q <= avg_curr;
            snap_t_q <= avg_torque;
            idx_q    <= 4'd0;
            csum_q   <= 8'h00;
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          trmt_q    <= 1'b1;
          tx_data_q <= cur_byte;
          if (idx_q >= 4'd2 && idx_q <= 4'd7) csum_q <= csum_q + cur_byte;
          guard_q   <= 1'b1;
          state_q   <= WAIT;
        end
        WAIT: begin
          // tx_done is still the previous byte's stale flag while trmt is high.
          guard_q <= 1'b0;
          if (!guard_q && tx_done) begin
            if (idx_q == 4'd8) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trmt    = trmt_q;
  assign tx_data = tx_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_telemetry_tx.sv
// Directed bench for telemetry_tx with an ideal UART done model (done 5 cycles after trmt).
module tb_telemetry_tx;
  localparam int P = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        tx_done;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  int dcnt;
  logic [7:0] bq[$];
  int         sq[$];
  logic       bsq[$];
  int         consec = 0;
  logic       prev_t = 1'b0;

  logic [7:0] F1[9] = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h07, 8'hFF, 8'h0F};
  logic [7:0] F2[9] = '{8'hAA, 8'h55, 8'h04, 8'h56, 8'h08, 8'h9A, 8'h0F, 8'hED, 8'h07};

  telemetry_tx #(.PERIOD_CYCLES(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .batt_v(batt_v), .avg_curr(avg_curr), .avg_torque(avg_torque),
    .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: samples trmt, clears done, raises it again 5 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b1;
      dcnt    <= 0;
    end else if (trmt) begin
      tx_done <= 1'b0;
      dcnt    <= 5;
    end else if (dcnt != 0) begin
      if (dcnt == 1) tx_done <= 1'b1;
      dcnt <= dcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (trmt) begin
        bq.push_back(tx_data);
        sq.push_back(cyc);
        bsq.push_back(busy);
        if (prev_t) consec++;
      end
      prev_t = trmt;
    end else begin
      prev_t = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (bq.size() < n && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    chk($sformatf("wait_bytes_%0d", n), 32'(bq.size() >= n), 32'd1);
  endtask

  task automatic clear_q();
    bq.delete(); sq.delete(); bsq.delete();
  endtask

  initial begin
    int k;
    int raise_cyc;
    int early;
    batt_v = 12'hABC; avg_curr = 12'h123; avg_torque = 12'h7FF;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_trmt", 32'(trmt), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Frame 1, with en dropped after the fourth byte.
    rst_n = 1'b1; en = 1'b1;
    wait_bytes(4);
    en = 1'b0;
    wait_bytes(9);
    k = 0;
    while (busy && k < 50) begin @(negedge clk); #1; k++; end
    chk("busy_end", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    #1;
    chk("no_frame_en0", 32'(bq.size()), 32'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("f1_b%0d", i), 32'(bq[i]), 32'(F1[i]));
    for (int i = 0; i < 8; i++) chk($sformatf("f1_gap%0d", i), 32'(sq[i+1] - sq[i]), 32'd8);
    for (int i = 0; i < 9; i++) chk($sformatf("f1_busy%0d", i), 32'(bsq[i]), 32'd1);

    // Frames 2 and 3 back-to-back, inputs changed mid-frame 2.
    clear_q();
    raise_cyc = cyc;
    en = 1'b1;
    wait_bytes(1);
    chk("restart_bound", 32'((sq[0] - raise_cyc) <= P + 3), 32'd1);
    wait_bytes(3);
    batt_v = 12'h456; avg_curr = 12'h89A; avg_torque = 12'hFED;
    wait_bytes(15);
    chk("trmt_pre_rst", 32'(trmt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_trmt", 32'(trmt), 32'd0);
    chk("arst_txdata", 32'(tx_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 9; i++) chk($sformatf("f2_b%0d", i), 32'(bq[i]), 32'(F1[i]));
    for (int i = 0; i < 6; i++) chk($sformatf("f3_b%0d", i), 32'(bq[9+i]), 32'(F2[i]));
    chk("b2b_gap", 32'(sq[9] - sq[8]), 32'd9);
    chk("f3_gap", 32'(sq[10] - sq[9]), 32'd8);
    chk("no_consec_trmt", 32'(consec), 32'd0);

    // After release: counter reloads, tick after P cycles, trmt two cycles later.
    rst_n = 1'b1;
    clear_q();
    early = 0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk); #1;
      if (trmt) early++;
    end
    chk("post_rst_quiet", 32'(early), 32'd0);
    @(negedge clk); #1;
    chk("post_rst_first_trmt", 32'(trmt), 32'd1);
    chk("post_rst_byte0", 32'(tx_data), 32'hAA);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
